// File: rtl/mem_burst_responder.sv
// rtl/mem_burst_responder.sv - big-endian byte/halfword/word/4-word burst memory responder
module mem_burst_responder #(
  parameter logic [31:0] mem_start = 32'h8002_0000,
  parameter int          mem_depth = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rd_wr,
  input  logic [1:0]  access_size,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        err
);

  localparam int          words   = mem_depth / 4;
  localparam int          idx_w   = $clog2(words);
  localparam logic [31:0] depth_b = 32'(mem_depth);

  localparam logic [1:0] st_idle     = 2'd0;
  localparam logic [1:0] st_burst_rd = 2'd1;
  localparam logic [1:0] st_burst_wr = 2'd2;

  localparam logic [1:0] sz_byte  = 2'b00;
  localparam logic [1:0] sz_word  = 2'b01;
  localparam logic [1:0] sz_half  = 2'b10;
  localparam logic [1:0] sz_burst = 2'b11;

  logic [31:0] mem [0:words-1];

  logic [1:0]       state;
  logic [1:0]       beat;
  logic [idx_w-3:0] line_q;

  logic [31:0]      offset;
  logic             in_range;
  logic             aligned;
  logic             req_ok;
  logic             accept;
  logic [idx_w-1:0] req_idx;
  logic [idx_w-1:0] cur_idx;
  logic [31:0]      rd_word;
  logic [31:0]      sub_rd;

  assign offset   = addr - mem_start;
  assign in_range = (addr >= mem_start) && (offset < depth_b);
  assign req_ok   = in_range && aligned;
  assign req_idx  = offset[idx_w+1:2];
  assign accept   = enable && (state == st_idle);
  // Bursts are 16-byte aligned, so beat simply replaces the low two word-index bits.
  assign cur_idx  = {line_q, beat};
  assign rd_word  = mem[req_idx];
  assign busy     = (state != st_idle);

  always_comb begin
    aligned = 1'b1;
    case (access_size)
      sz_half:  aligned = ~offset[0];
      sz_word:  aligned = (offset[1:0] == 2'b00);
      sz_burst: aligned = (offset[3:0] == 4'h0);
      default:  aligned = 1'b1;
    endcase
  end

  always_comb begin
    sub_rd = rd_word;
    case (access_size)
      sz_byte: begin
        case (offset[1:0])
          2'd0:    sub_rd = {24'h0, rd_word[31:24]};
          2'd1:    sub_rd = {24'h0, rd_word[23:16]};
          2'd2:    sub_rd = {24'h0, rd_word[15:8]};
          default: sub_rd = {24'h0, rd_word[7:0]};
        endcase
      end
      sz_half: sub_rd = offset[1] ? {16'h0, rd_word[15:0]} : {16'h0, rd_word[31:16]};
      default: sub_rd = rd_word;
    endcase
  end

  // Array has no reset; writes are suppressed while reset is held so an aborted burst stops cleanly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept && req_ok && !rd_wr) begin
        case (access_size)
          sz_byte: begin
            case (offset[1:0])
              2'd0:    mem[req_idx][31:24] <= data_in[7:0];
              2'd1:    mem[req_idx][23:16] <= data_in[7:0];
              2'd2:    mem[req_idx][15:8]  <= data_in[7:0];
              default: mem[req_idx][7:0]   <= data_in[7:0];
            endcase
          end
          sz_half: begin
            if (offset[1]) mem[req_idx][15:0]  <= data_in[15:0];
            else           mem[req_idx][31:16] <= data_in[15:0];
          end
          default: mem[req_idx] <= data_in;
        endcase
      end else if (state == st_burst_wr) begin
        mem[cur_idx] <= data_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= st_idle;
      beat     <= 2'd0;
      line_q   <= '0;
      data_out <= 32'h0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        st_idle: begin
          if (enable) begin
            if (!req_ok) begin
              err      <= 1'b1;
              data_out <= 32'h0;
            end else if (access_size == sz_burst) begin
              state  <= rd_wr ? st_burst_rd : st_burst_wr;
              beat   <= 2'd1;
              line_q <= req_idx[idx_w-1:2];
              if (rd_wr) data_out <= rd_word;
            end else if (rd_wr) begin
              data_out <= sub_rd;
            end
          end
        end
        st_burst_rd, st_burst_wr: begin
          if (state == st_burst_rd) data_out <= mem[cur_idx];
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= st_idle;
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: doc/mem_burst_responder.md
# mem_burst_responder

Memory-side responder for the processor's memory port (`addr`/`data_in`/`access_size`/`rd_wr`/`enable`/`data_out`/`busy`). It services byte, halfword, word and 4-word burst reads and writes from an internal word array, and uses `busy` to stall the initiator during bursts. Backing store is big-endian, matching the MIPS core. It replaces the flat word-only data memory on the data side and is the block the core's load/store path and the future cache refill path talk to.

## Interface
Parameters:
- `mem_start`, 32'h8002_0000, byte address of the first location.
- `mem_depth`, 16384, size in bytes; multiple of 16.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  request valid; sampled only while `busy`=0.
- `rd_wr`  in  1  1 = read, 0 = write.
- `access_size`  in  2  00 byte, 01 word, 10 halfword, 11 4-word burst.
- `addr`  in  32  byte address of the access (first beat for a burst).
- `data_in`  in  32  write data; byte in [7:0], halfword in [15:0].
- `data_out`  out  32  registered read data; byte/halfword zero-extended into the low bits.
- `busy`  out  1  burst in progress; new requests are ignored while high.
- `err`  out  1  one-cycle pulse for a rejected request.

## Operation
- Accept: a request is accepted on a rising edge where `enable`=1 and `busy`=0.
- Range check: `addr` must lie in [`mem_start`, `mem_start`+`mem_depth`).
  - Offset = `addr` − `mem_start`. Word index = offset[31:2].
- Alignment check:
  - halfword: offset[0]=0.
  - word: offset[1:0]=0.
  - burst: offset[3:0]=0.
- Rejected request (out of range or misaligned): `err`=1 for the following cycle, no write, `data_out`=0, `busy` stays 0.
- Big-endian lanes:
  - Byte lane for offset[1:0]=0 is word bits [31:24]; offset[1:0]=3 is [7:0].
  - Halfword at offset[1]=0 is [31:16].
- Sub-word writes modify only the addressed lane; the other bytes are preserved.
- Single reads: `data_out` is zero-extended. Sign extension is the core's job.
- State machine: IDLE, BURST_RD, BURST_WR; 2-bit beat counter.
  - IDLE: accepting a burst goes to BURST_RD or BURST_WR with beat=1. Single accesses stay in IDLE.
  - BURST_*: beat increments each edge; returns to IDLE on the edge that processes beat 3.
  - Beat k addresses word index base+k. There is no wrap, because alignment guarantees the burst stays inside one 16-byte line.
- While in BURST_*, `enable`, `addr`, `access_size` and `rd_wr` are ignored. `data_in` is sampled on burst-write beats.
- `data_out` holds its last value after writes, rejected requests excepted (those force 0), and while idle.
- Reset:
  - Forces IDLE, `busy`=0, `err`=0, `data_out`=0, beat=0.
  - Array contents are not cleared.
  - Reset mid-burst aborts the burst: beats already written are kept, remaining beats are not written.

## Timing
- Single read accepted at edge N: `data_out` is valid after edge N and held until the next read or reject.
- Single write accepted at edge N: array updated at edge N. A read accepted at edge N+1 returns the new data.
- Burst accepted at edge N:
  - `busy`=1 after edges N, N+1 and N+2; `busy`=0 after edge N+3.
  - Next request can be accepted at edge N+4.
- Burst read: `data_out` = word base+0..3 after edges N, N+1, N+2, N+3 respectively.
- Burst write: `data_in` sampled at edges N, N+1, N+2, N+3 for words base+0..3.
- `err` rises after the accept edge and falls after the next edge.
- `busy` and `err` are never high together.

## Test plan
- Reset/idle: assert `reset` asynchronously mid-cycle → `data_out`=0, `busy`=0, `err`=0 immediately; `enable`=0 for 5 cycles → no change.
- Word write then read:
  - Write 32'hDEADBEEF at `mem_start`+8, then read at edge N+1 → `data_out`=32'hDEADBEEF after edge N+1.
  - Byte read at +9 → 32'h000000AD.
  - Halfword read at +10 → 32'h0000BEEF.
- Sub-word write: byte write 8'h11 at `mem_start`+11 → word read at +8 = 32'hDEADBE11. Halfword write 16'h2233 at +8 → 32'h2233BE11.
- Burst write/read:
  - Burst write at `mem_start`+16 with data 1,2,3,4 on consecutive edges → `busy` high for exactly 3 cycles.
  - Burst read at the same address → `data_out` sequence 1,2,3,4.
  - An `enable` pulse while `busy`=1 is ignored.
- Rejects → `err` pulse for one cycle, `data_out`=0, memory unchanged, for each of:
  - word read at `mem_start`+2;
  - burst at `mem_start`+4;
  - write at `mem_start`+`mem_depth`;
  - read at `mem_start`−4.
- Reset mid-burst: burst write 9,8,7,6 over old value 0 at `mem_start`+32, with `reset` asserted after beat 1 is sampled → read-back gives 9,8,0,0 and `busy`=0.
